// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit.
package bru_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            hit;
        logic [XLEN-1:0] target;
    } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of fetch-time BTB predictions awaiting resolution.
module pred_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  pred_entry_t entry_i,
    output pred_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    pred_entry_t   mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves recorded fetch predictions in execute: BTB update, redirect, stats.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_valid,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            pred_hit,
    input  logic [XLEN-1:0] pred_target,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic            res_is_branch,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    output logic            btb_upd_valid,
    output logic [XLEN-1:0] btb_upd_pc,
    output logic [XLEN-1:0] btb_upd_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count,
    output logic            underflow
);

    pred_entry_t head;
    pred_entry_t push_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        flush;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pred_next;
    logic [XLEN-1:0] act_next;
    logic            actual_taken;
    logic            mispredict;
    logic            need_upd;

    logic            upd_valid_q;
    logic [XLEN-1:0] upd_pc_q;
    logic [XLEN-1:0] upd_tgt_q;
    logic            redir_valid_q;
    logic [XLEN-1:0] redir_pc_q;
    logic [31:0]     br_cnt_q;
    logic [31:0]     mp_cnt_q;
    logic            underflow_q;

    assign pred_ready = !fifo_full;
    // Fetch is still on the wrong path during the redirect cycle.
    assign push = pred_valid && pred_ready && !redir_valid_q;
    assign pop  = res_valid && !fifo_empty;

    assign push_entry.pc     = pred_pc;
    assign push_entry.hit    = pred_hit;
    assign push_entry.target = pred_target;

    assign pc_plus4     = head.pc + 32'd4;
    assign actual_taken = res_is_branch && res_taken;
    assign pred_next    = head.hit ? head.target : pc_plus4;
    assign act_next     = actual_taken ? res_target : pc_plus4;
    assign mispredict   = (pred_next != act_next);
    assign need_upd     = actual_taken &&
                          (!head.hit || head.target != res_target);
    assign flush        = pop && mispredict;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .entry_i (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_tgt_q     <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            br_cnt_q      <= '0;
            mp_cnt_q      <= '0;
            underflow_q   <= 1'b0;
        end else begin
            upd_valid_q   <= pop && need_upd;
            redir_valid_q <= flush;
            if (pop && need_upd) begin
                upd_pc_q  <= head.pc;
                upd_tgt_q <= res_target;
            end
            if (flush) begin
                redir_pc_q <= act_next;
                mp_cnt_q   <= mp_cnt_q + 32'd1;
            end
            if (pop && res_is_branch) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (res_valid && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign btb_upd_valid    = upd_valid_q;
    assign btb_upd_pc       = upd_pc_q;
    assign btb_upd_target   = upd_tgt_q;
    assign redirect_valid   = redir_valid_q;
    assign redirect_pc      = redir_pc_q;
    assign branch_count     = br_cnt_q;
    assign mispredict_count = mp_cnt_q;
    assign underflow        = underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit with directed vectors.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic        pred_ready;
    logic        res_valid;
    logic        res_is_branch;
    logic        res_taken;
    logic [31:0] res_target;
    logic        btb_upd_valid;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        rd;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_hit         (pred_hit),
        .pred_target      (pred_target),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_is_branch    (res_is_branch),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .btb_upd_valid    (btb_upd_valid),
        .btb_upd_pc       (btb_upd_pc),
        .btb_upd_target   (btb_upd_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .underflow        (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (btb_upd_valid === 1'b1 || redirect_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: upd=%b redir=%b want none",
                         btb_upd_valid, redirect_valid);
            end else begin
                mon_e = exp_q.pop_front();
                chk("upd_valid", {31'd0, btb_upd_valid}, {31'd0, mon_e.upd});
                if (mon_e.upd) begin
                    chk("upd_pc", btb_upd_pc, mon_e.upc);
                    chk("upd_tgt", btb_upd_target, mon_e.utgt);
                end
                chk("redir_valid", {31'd0, redirect_valid}, {31'd0, mon_e.rd});
                if (mon_e.rd) chk("redir_pc", redirect_pc, mon_e.rpc);
            end
        end
    end

    task automatic expect_pulse(input logic upd, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic rd,
                                input logic [31:0] rpc);
        exp_t e;
        e.upd  = upd;
        e.upc  = upc;
        e.utgt = utgt;
        e.rd   = rd;
        e.rpc  = rpc;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the edge.
    task automatic cyc(input logic pv, input logic [31:0] ppc,
                       input logic ph, input logic [31:0] pt,
                       input logic rv, input logic rb, input logic rt,
                       input logic [31:0] rtg);
        pred_valid    = pv;
        pred_pc       = ppc;
        pred_hit      = ph;
        pred_target   = pt;
        res_valid     = rv;
        res_is_branch = rb;
        res_taken     = rt;
        res_target    = rtg;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic hit,
                        input logic [31:0] tgt);
        cyc(1'b1, pc, hit, tgt, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic rb, input logic rt,
                           input logic [31:0] rtg);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rb, rt, rtg);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, {31'd0, pred_ready}, 32'd1);
        chk({tag, "_upd_v"}, {31'd0, btb_upd_valid}, 32'd0);
        chk({tag, "_upd_pc"}, btb_upd_pc, 32'd0);
        chk({tag, "_upd_tgt"}, btb_upd_target, 32'd0);
        chk({tag, "_redir_v"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_redir_pc"}, redirect_pc, 32'd0);
        chk({tag, "_bcnt"}, branch_count, 32'd0);
        chk({tag, "_mcnt"}, mispredict_count, 32'd0);
        chk({tag, "_uflow"}, {31'd0, underflow}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        chk_reset_state("rst");
        rst = 1'b0;

        // Non-branch resolves cleanly
        push(32'h100, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 32'h0);
        idle();
        chk("t1_bcnt", branch_count, 32'd0);
        chk("t1_mcnt", mispredict_count, 32'd0);

        // Taken branch, BTB miss: update plus redirect
        push(32'h200, 1'b0, 32'h0);
        expect_pulse(1'b1, 32'h200, 32'h400, 1'b1, 32'h400);
        resolve(1'b1, 1'b1, 32'h400);
        chk("t2_mcnt", mispredict_count, 32'd1);
        chk("t2_bcnt", branch_count, 32'd1);
        idle();
        chk("t2_hold_redir_v", {31'd0, redirect_valid}, 32'd0);
        chk("t2_hold_redir_pc", redirect_pc, 32'h400);
        chk("t2_hold_upd_pc", btb_upd_pc, 32'h200);

        // Predicted taken, actually not taken; younger entries flushed
        push(32'h300, 1'b1, 32'h500);
        push(32'h310, 1'b0, 32'h0);
        push(32'h320, 1'b0, 32'h0);
        expect_pulse(1'b0, 32'h0, 32'h0, 1'b1, 32'h304);
        cyc(1'b1, 32'h330, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h999);
        chk("t3_mcnt", mispredict_count, 32'd2);
        push(32'h340, 1'b0, 32'h0);
        idle();

        // Hit with wrong target; head must be this push if flush worked
        push(32'h300, 1'b1, 32'h500);
        expect_pulse(1'b1, 32'h300, 32'h600, 1'b1, 32'h600);
        resolve(1'b1, 1'b1, 32'h600);
        chk("t4_mcnt", mispredict_count, 32'd3);
        idle();
        push(32'h300, 1'b1, 32'h500);
        resolve(1'b1, 1'b1, 32'h500);
        idle();
        chk("t4b_bcnt", branch_count, 32'd4);
        chk("t4b_mcnt", mispredict_count, 32'd3);

        // Fill to DEPTH, drop fifth push, pop+push at full
        push(32'h1000, 1'b0, 32'h0);
        push(32'h1004, 1'b0, 32'h0);
        push(32'h1008, 1'b0, 32'h0);
        chk("t5_ready3", {31'd0, pred_ready}, 32'd1);
        push(32'h100c, 1'b0, 32'h0);
        chk("t5_full", {31'd0, pred_ready}, 32'd0);
        push(32'h2000, 1'b0, 32'h0);
        chk("t5_drop", {31'd0, pred_ready}, 32'd0);
        cyc(1'b1, 32'h2004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5_popfull", {31'd0, pred_ready}, 32'd1);
        push(32'h3000, 1'b0, 32'h0);
        chk("t5_refill", {31'd0, pred_ready}, 32'd0);
        resolve(1'b0, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 32'h0);
        resolve(1'b1, 1'b0, 32'h0);
        expect_pulse(1'b1, 32'h3000, 32'h3100, 1'b1, 32'h3100);
        resolve(1'b1, 1'b1, 32'h3100);
        chk("t5_bcnt", branch_count, 32'd6);
        chk("t5_mcnt", mispredict_count, 32'd4);
        idle();

        // Resolve on empty queue
        chk("t6_uflow0", {31'd0, underflow}, 32'd0);
        resolve(1'b1, 1'b1, 32'h4444);
        chk("t6_uflow1", {31'd0, underflow}, 32'd1);
        idle();
        idle();
        chk("t6_sticky", {31'd0, underflow}, 32'd1);
        chk("t6_bcnt", branch_count, 32'd6);

        // Reset wins over a mispredicting resolve
        push(32'h500, 1'b0, 32'h0);
        rst = 1'b1;
        resolve(1'b1, 1'b1, 32'h900);
        chk_reset_state("mid_rst");
        rst = 1'b0;
        idle();
        chk("post_rst_redir", {31'd0, redirect_valid}, 32'd0);
        idle();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage counterpart of the fetch-side BTB lookup. Records each fetch-time prediction in an in-order queue, and compares it against the actual outcome when the instruction resolves in execute. From that comparison it drives the BTB update port (`valid_in` / `branch_PC` / `branch_target`) and issues a single-cycle front-end redirect on mispredict. It also keeps branch and mispredict statistics.

## Interface
- `DEPTH`, 4: prediction queue entries; power of 2, ≥2; covers in-flight IF→EX instructions.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `pred_valid` in 1: fetch records one prediction this cycle.
- `pred_pc` in 32: fetched PC.
- `pred_hit` in 1: BTB `is_branch_inst` for `pred_pc`.
- `pred_target` in 32: BTB `target_addr` for `pred_pc`.
- `pred_ready` out 1: queue not full.
- `res_valid` in 1: oldest recorded instruction resolves this cycle.
- `res_is_branch` in 1: resolved instruction is a branch/jump.
- `res_taken` in 1: actual direction; ignored unless `res_is_branch`.
- `res_target` in 32: actual taken target.
- `btb_upd_valid` out 1: drives BTB `valid_in`.
- `btb_upd_pc` out 32: drives BTB `branch_PC`.
- `btb_upd_target` out 32: drives BTB `branch_target`.
- `redirect_valid` out 1: front-end redirect pulse.
- `redirect_pc` out 32: correct next PC.
- `branch_count` out 32: resolved branches.
- `mispredict_count` out 32: mispredicts.
- `underflow` out 1: sticky flag; set when `res_valid` arrives with the queue empty.

## Operation
- **Push:** accepted iff `pred_valid && pred_ready && !redirect_valid`. Stores {pc, hit, target}.
- **Push when full:** dropped, no state change.
- **Pop:** on `res_valid` with queue non-empty. Compare head against the resolution combinationally in the same cycle:
  - pred_next = hit ? target : pc+4
  - act_next = (res_is_branch && res_taken) ? res_target : pc+4
  - All adds are mod 2^32.
  - mispredict = pred_next != act_next.
- **BTB update:** condition is `res_is_branch && res_taken && (!hit || target != res_target)`.
  - Sets `btb_upd_valid` with upd_pc = head pc and upd_target = `res_target`.
  - No update for not-taken branches; the BTB has no invalidate.
- **Mispredict:**
  - `redirect_valid` is asserted with `redirect_pc` = act_next.
  - Queue is flushed (count = 0, pointers reset), discarding all younger entries, including a push in the same cycle.
  - `mispredict_count`++.
- **Branch count:** `branch_count`++ on every pop with `res_is_branch`.
- **Empty queue:** `res_valid` while empty (or in the `redirect_valid` cycle, when the queue is empty by construction) is ignored except for setting `underflow`.
- **Simultaneous push + pop, no mispredict:** both occur; count unchanged. Allowed when full only as pop (`pred_ready` is low, so the push is dropped).
- **Pointers:** log2(DEPTH) bits, wrap naturally.
- **Count:** log2(DEPTH)+1 bits.
- **Statistics counters:** wrap at 2^32.

## Timing
- All outputs except `pred_ready` are registered. Resolution in cycle N produces outputs in cycle N+1 as 1-cycle pulses.
- `pred_ready` is combinational from count (`count != DEPTH`) and is not gated by `redirect_valid`.
- Flush takes effect at the edge ending cycle N. Pushes in N+1 (the `redirect_valid` cycle) are dropped, because fetch is still on the wrong path.
- **Reset values:**
  - Queue empty; `pred_ready` = 1.
  - `btb_upd_valid` = 0, `btb_upd_pc` = 0, `btb_upd_target` = 0.
  - `redirect_valid` = 0, `redirect_pc` = 0.
  - Both counters = 0; `underflow` = 0.
- **Reset mid-operation:** `rst` overrides push, pop and flush in the same cycle. Any pulse pending for the next cycle is suppressed.
- **Idle outputs:** `btb_upd_pc` / `btb_upd_target` / `redirect_pc` hold their last values when their valid is low.
- **Update vs redirect:** BTB update and redirect may assert in the same cycle (taken branch, BTB miss).

## Structure
- Package `bru_pkg`: `pred_entry_t` struct {pc[31:0], hit, target[31:0]} and `XLEN`=32.
- Sub-module `pred_fifo`: synchronous FIFO of `pred_entry_t`, parameter DEPTH, with push/pop/flush/full/empty and head read.
- Compare logic, output registers and counters live in the top.

## Test plan
- Reset, then push {pc=0x100, hit=0}. Resolve not-branch → no `btb_upd_valid`, no redirect, `branch_count`=0, queue empty.
- Push {0x200, hit=0}. Resolve branch taken to 0x400 → N+1: `btb_upd_valid`, `btb_upd_pc`=0x200, `btb_upd_target`=0x400, `redirect_pc`=0x400, `mispredict_count`=1.
- Push {0x300, hit=1, target=0x500} plus 2 younger entries. Resolve not-taken → `redirect_pc`=0x304, no BTB update. Queue empties; push in the redirect cycle is dropped.
- Push {0x300, hit=1, target=0x500}. Resolve taken to 0x600 → BTB update to 0x600 and redirect 0x600. Resolve the same again with hit/0x500 matching 0x500 → no outputs, `branch_count` incremented.
- Fill DEPTH=4 → `pred_ready`=0. 5th push is dropped. Simultaneous pop+push at full → count goes to 3, then back to 4 next push.
- `res_valid` on empty queue → `underflow`=1 and stays set. `rst` asserted in the same cycle as a mispredicting resolve → no redirect pulse, all outputs at reset values.
